// File: rtl/sign_extender_if.sv
// Capture handshake between the instruction decoder and the registered extension path.
// The master drives capture requests; the slave returns the registered operand and its strobe.
interface sign_extender_if;
    logic        in_valid;
    logic [1:0]  sel;
    logic        zext;
    logic [15:0] ext_out;
    logic        ext_valid;

    modport master (
        output in_valid,
        output sel,
        output zext,
        input  ext_out,
        input  ext_valid
    );

    modport slave (
        input  in_valid,
        input  sel,
        input  zext,
        output ext_out,
        output ext_valid
    );
endinterface

// File: rtl/sign_extender.sv
// 16-bit sign extension of the 6/8/10-bit immediate fields plus a registered, field-selectable operand path.
// Define SIGN_EXT_ZEXT_EN to let cap.zext request zero extension on the registered path.
module sign_extender (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      in6,
    input  logic [7:0]      in8,
    input  logic [9:0]      in10,
    output logic [15:0]     out6,
    output logic [15:0]     out8,
    output logic [15:0]     out10,
    sign_extender_if.slave  cap
);

    logic [15:0] next_val;

    assign out6  = {{10{in6[5]}}, in6};
    assign out8  = {{8{in8[7]}}, in8};
    assign out10 = {{6{in10[9]}}, in10};

    // Reserved select 11 yields zero in both extension modes.
    always_comb begin
        next_val = 16'h0000;
        case (cap.sel)
            2'b00:   next_val = out6;
            2'b01:   next_val = out8;
            2'b10:   next_val = out10;
            default: next_val = 16'h0000;
        endcase
`ifdef SIGN_EXT_ZEXT_EN
        if (cap.zext) begin
            case (cap.sel)
                2'b00:   next_val = {10'b0, in6};
                2'b01:   next_val = {8'b0, in8};
                2'b10:   next_val = {6'b0, in10};
                default: next_val = 16'h0000;
            endcase
        end
`endif
    end

`ifndef SIGN_EXT_ZEXT_EN
    logic unused_zext;
    assign unused_zext = cap.zext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap.ext_out   <= 16'h0000;
            cap.ext_valid <= 1'b0;
        end else begin
            cap.ext_valid <= cap.in_valid;
            if (cap.in_valid) begin
                cap.ext_out <= next_val;
            end
        end
    end

endmodule

// File: tb/tb_sign_extender.sv
// Directed bench for sign_extender: combinational extenders checked against constants and an
// arithmetic model, registered path checked through an expected-result queue.
module tb_sign_extender;

    logic        clk;
    logic        rst_n;
    logic [5:0]  in6;
    logic [7:0]  in8;
    logic [9:0]  in10;
    logic [15:0] out6;
    logic [15:0] out8;
    logic [15:0] out10;

    sign_extender_if bus ();

    sign_extender dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in6   (in6),
        .in8   (in8),
        .in10  (in10),
        .out6  (out6),
        .out8  (out8),
        .out10 (out10),
        .cap   (bus.slave)
    );

`ifdef SIGN_EXT_ZEXT_EN
    localparam bit ZEXT_ON = 1'b1;
`else
    localparam bit ZEXT_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_out;
    int          n_vectors;
    int          n_miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Two's-complement value of a w-bit field, computed arithmetically.
    function automatic logic [15:0] sx(input int f, input int w);
        int v;
        v = f;
        if (f >= (1 << (w - 1))) v = f - (1 << w);
        return v[15:0];
    endfunction

    function automatic logic [15:0] model_ext(input logic [1:0] s, input logic z,
                                              input logic [5:0] f6, input logic [7:0] f8,
                                              input logic [9:0] f10);
        logic zx;
        zx = z && ZEXT_ON;
        case (s)
            2'b00:   return zx ? 16'(int'(f6))  : sx(int'(f6), 6);
            2'b01:   return zx ? 16'(int'(f8))  : sx(int'(f8), 8);
            2'b10:   return zx ? 16'(int'(f10)) : sx(int'(f10), 10);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_vectors++;
        assert (observed === expected) else begin
            n_miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of the capture interface, queue the expected result, then check it after the edge.
    task automatic applyStimulus(input string tag, input logic v, input logic [1:0] s, input logic z,
                                 input logic [5:0] f6, input logic [7:0] f8, input logic [9:0] f10);
        exp_t e;
        bus.in_valid = v;
        bus.sel      = s;
        bus.zext     = z;
        in6          = f6;
        in8          = f8;
        in10         = f10;
        if (v) model_out = model_ext(s, z, f6, f8, f10);
        e.data  = model_out;
        e.valid = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({tag, ".out"}, bus.ext_out, e.data);
        checkOutput({tag, ".valid"}, {15'b0, bus.ext_valid}, {15'b0, e.valid});
    endtask

    task automatic checkComb(input string tag, input logic [5:0] f6, input logic [7:0] f8, input logic [9:0] f10);
        in6  = f6;
        in8  = f8;
        in10 = f10;
        #1;
        checkOutput({tag, ".out6"},  out6,  sx(int'(f6), 6));
        checkOutput({tag, ".out8"},  out8,  sx(int'(f8), 8));
        checkOutput({tag, ".out10"}, out10, sx(int'(f10), 10));
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        model_out     = 16'h0000;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sel       = 2'b01;
        bus.zext      = 1'b0;
        in6           = 6'h00;
        in8           = 8'h55;
        in10          = 10'h000;

        // Capture requested while in reset must be discarded.
        @(posedge clk);
        #1;
        checkOutput("reset.out", bus.ext_out, 16'h0000);
        checkOutput("reset.valid", {15'b0, bus.ext_valid}, 16'h0000);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset.valid", {15'b0, bus.ext_valid}, 16'h0000);

        in8 = 8'hFF;
        #1 checkOutput("comb8.ff", out8, 16'hFFFF);
        in10 = 10'h3FF;
        #1 checkOutput("comb10.3ff", out10, 16'hFFFF);
        in10 = 10'h1FF;
        #1 checkOutput("comb10.1ff", out10, 16'h01FF);
        in10 = 10'h0FF;
        #1 checkOutput("comb10.0ff", out10, 16'h00FF);
        in6 = 6'h3F;
        #1 checkOutput("comb6.3f", out6, 16'hFFFF);
        in6 = 6'h00;
        #1 checkOutput("comb6.00", out6, 16'h0000);
        in6 = 6'h1F;
        #1 checkOutput("comb6.1f", out6, 16'h001F);
        checkComb("comb.max", 6'h1F, 8'h7F, 10'h1FF);
        checkComb("comb.min", 6'h20, 8'h80, 10'h200);
        for (int i = 0; i < 8; i++) begin
            checkComb("comb.rand", 6'($urandom), 8'($urandom), 10'($urandom));
        end

        @(posedge clk);
        #1;
        applyStimulus("b2b.sel00", 1'b1, 2'b00, 1'b0, 6'h20, 8'h7F, 10'h200);
        checkOutput("b2b.sel00.const", bus.ext_out, 16'hFFE0);
        applyStimulus("b2b.sel01", 1'b1, 2'b01, 1'b0, 6'h20, 8'h7F, 10'h200);
        checkOutput("b2b.sel01.const", bus.ext_out, 16'h007F);
        applyStimulus("b2b.sel10", 1'b1, 2'b10, 1'b0, 6'h20, 8'h7F, 10'h200);
        checkOutput("b2b.sel10.const", bus.ext_out, 16'hFE00);
        applyStimulus("hold.1", 1'b0, 2'b00, 1'b0, 6'h01, 8'h02, 10'h003);
        checkOutput("hold.const", bus.ext_out, 16'hFE00);
        applyStimulus("hold.2", 1'b0, 2'b01, 1'b1, 6'h3F, 8'hFF, 10'h3FF);

        applyStimulus("max.sel00", 1'b1, 2'b00, 1'b0, 6'h1F, 8'h80, 10'h1FF);
        applyStimulus("min.sel01", 1'b1, 2'b01, 1'b0, 6'h1F, 8'h80, 10'h1FF);
        applyStimulus("max.sel10", 1'b1, 2'b10, 1'b0, 6'h1F, 8'h80, 10'h1FF);
        applyStimulus("reserved", 1'b1, 2'b11, 1'b0, 6'h3F, 8'hFF, 10'h3FF);
        checkOutput("reserved.const", bus.ext_out, 16'h0000);

        applyStimulus("zext.sel10", 1'b1, 2'b10, 1'b1, 6'h00, 8'h00, 10'h3FF);
        checkOutput("zext.sel10.const", bus.ext_out, ZEXT_ON ? 16'h03FF : 16'hFFFF);
        applyStimulus("zext.sel01", 1'b1, 2'b01, 1'b1, 6'h00, 8'hFF, 10'h000);
        checkOutput("zext.sel01.const", bus.ext_out, ZEXT_ON ? 16'h00FF : 16'hFFFF);
        applyStimulus("zext.sel11", 1'b1, 2'b11, 1'b1, 6'h3F, 8'hFF, 10'h3FF);

        for (int i = 0; i < 40; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
                          6'($urandom), 8'($urandom), 10'($urandom));
        end

        // Asynchronous reset between edges, with a nonzero result pending.
        applyStimulus("pre_reset", 1'b1, 2'b01, 1'b0, 6'h00, 8'h80, 10'h000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset.out", bus.ext_out, 16'h0000);
        checkOutput("async_reset.valid", {15'b0, bus.ext_valid}, 16'h0000);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_reset.out", bus.ext_out, 16'h0000);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b1;
        model_out = 16'h0000;
        applyStimulus("no_replay", 1'b0, 2'b01, 1'b0, 6'h00, 8'h80, 10'h000);
        applyStimulus("first_capture", 1'b1, 2'b00, 1'b0, 6'h2A, 8'h00, 10'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
